completion_returner: RTL

COMPLETION_RETURNER -- requirements
Module: completion_returner

---
 rtl/completion_returner.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/completion_returner.sv
// completion_returner
//   Buffers back-end completions in a small FIFO and presents them, one at a
//   time and in acceptance order, through a registered output stage to the
//   front end with a valid/ready handshake.
//
//   Optional feature: define COMPLETION_BYPASS_EN to let a completion skip the
//   FIFO when it is empty and the output register can take it, cutting the
//   acceptance-to-valid latency from two edges to one. Without the macro every
//   completion goes through the FIFO.

module completion_returner #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 6,
  parameter int DEPTH       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmp_valid,
  input  logic                       cmp_type,
  input  logic [DATA_WIDTH-1:0]      cmp_data,
  input  logic [INDEX_WIDTH-1:0]     cmp_index,
  output logic                       cmp_ready,
  output logic                       request_done_valid,
  output logic                       the_type,
  output logic [DATA_WIDTH-1:0]      data_in,
  output logic [INDEX_WIDTH-1:0]     index,
  input  logic                       done_ready,
  output logic [$clog2(DEPTH)+1:0]   fill_level
);

  // Address width of the FIFO; pointers carry one extra wrap bit.
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 2;

  // FIFO storage, one array per completion field
  logic                   mem_type_q  [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_data_q  [DEPTH];
  logic [INDEX_WIDTH-1:0] mem_index_q [DEPTH];

  // Pointers with wrap bit: equal means empty, only-MSB-differs means full
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  // Output register holding the completion currently offered to the front end
  logic                   out_valid_q, out_valid_d;
  logic                   out_type_q,  out_type_d;
  logic [DATA_WIDTH-1:0]  out_data_q,  out_data_d;
  logic [INDEX_WIDTH-1:0] out_index_q, out_index_d;

  // Registered occupancy: FIFO entries plus the output register
  logic [FW-1:0] fill_level_q, fill_level_d;

  // Handshake and datapath control
  logic          fifo_empty;
  logic          fifo_full;
  logic          accept;
  logic          retire;
  logic          slot_free;
  logic          pop;
  logic          push;
  logic          bypass;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   fifo_count_d;

  // Status and handshake decode, derived only from registered state and inputs
  always_comb begin
    wr_addr    = wr_ptr_q[AW-1:0];
    rd_addr    = rd_ptr_q[AW-1:0];
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    cmp_ready  = !fifo_full;
    accept     = cmp_valid && !fifo_full;
    retire     = out_valid_q && done_ready;
    slot_free  = !out_valid_q || retire;
    pop        = slot_free && !fifo_empty;
`ifdef COMPLETION_BYPASS_EN
    bypass     = slot_free && fifo_empty && accept;
`else
    bypass     = 1'b0;
`endif
    push       = accept && !bypass;
  end

  // Next-state for pointers, output register and occupancy
  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
    out_valid_d = out_valid_q;
    out_type_d  = out_type_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_type_d  = mem_type_q[rd_addr];
      out_data_d  = mem_data_q[rd_addr];
      out_index_d = mem_index_q[rd_addr];
    end else if (bypass) begin
      out_valid_d = 1'b1;
      out_type_d  = cmp_type;
      out_data_d  = cmp_data;
      out_index_d = cmp_index;
    end else if (retire) begin
      out_valid_d = 1'b0;
    end
    fifo_count_d = wr_ptr_d - rd_ptr_d;
    fill_level_d = FW'(fifo_count_d) + FW'(out_valid_d);
  end

  // FIFO write port; entries need no reset because the pointers track validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_type_q[wr_addr]  <= cmp_type;
      mem_data_q[wr_addr]  <= cmp_data;
      mem_index_q[wr_addr] <= cmp_index;
    end
  end

  // Control and output state; reset discards everything buffered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_type_q   <= 1'b0;
      out_data_q   <= '0;
      out_index_q  <= '0;
      fill_level_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_valid_q  <= out_valid_d;
      out_type_q   <= out_type_d;
      out_data_q   <= out_data_d;
      out_index_q  <= out_index_d;
      fill_level_q <= fill_level_d;
    end
  end

  assign request_done_valid = out_valid_q;
  assign the_type           = out_type_q;
  assign data_in            = out_data_q;
  assign index              = out_index_q;
  assign fill_level         = fill_level_q;

endmodule
